// File: rtl/priv_memory_responder.sv
// priv_memory_responder: privileged word array with region permissions, violation tracking, config lock and post-reset scrub
// Ports: clk/reset (sync, active-high); priv_addr/priv_write_data/priv_write_enable/req_level request in;
// priv_read_data registered read out; ready scrub done; locked config write-lock; viol_irq/viol_addr/viol_count violation status.
module priv_memory_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] LOCK_ADDR = 8'h7F,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] priv_addr,
  input  logic [DATA_W-1:0] priv_write_data,
  input  logic              priv_write_enable,
  input  logic [1:0]        req_level,
  output logic [DATA_W-1:0] priv_read_data,
  output logic              ready,
  output logic              locked,
  output logic              viol_irq,
  output logic [ADDR_W-1:0] viol_addr,
  output logic [7:0]        viol_count
);
  typedef enum logic {SCRUB, RUN} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [1:0] w_region;
  logic w_run, w_wr_ok, w_mask, w_viol, w_wr;
  assign w_region = priv_addr[ADDR_W-1:ADDR_W-2];
  assign w_run = r_state == RUN;
  assign w_wr_ok = (w_region == 2'b00) | (w_region == 2'b01 & req_level[1] & ~locked) | (w_region[1] & &req_level);
  assign w_mask = &w_region & ~&req_level;
  // a write attempt is judged only as a write, so a masked key read never counts twice
  assign w_viol = w_run & (priv_write_enable ? ~w_wr_ok : w_mask);
  assign w_wr = w_run & priv_write_enable & w_wr_ok;
  always_ff @(posedge clk)
    r_state <= reset ? SCRUB : w_next;
  always_comb begin
    w_next = (r_state == SCRUB && &r_ptr) ? RUN : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      ready <= 1'b0;
      locked <= 1'b0;
      viol_irq <= 1'b0;
      viol_addr <= '0;
      viol_count <= '0;
      priv_read_data <= '0;
    end else begin
      r_ptr <= w_run ? r_ptr : r_ptr + 1'b1;
      ready <= w_next == RUN;
      priv_read_data <= (w_run && !w_mask) ? r_mem[priv_addr] : '0;
      viol_irq <= w_viol;
      if (w_viol && viol_count == 8'h00) viol_addr <= priv_addr;
      if (w_viol && viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
      if (w_wr && priv_addr == LOCK_ADDR && priv_write_data[0]) locked <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!w_run) r_mem[r_ptr] <= INIT_VALUE;
      else if (w_wr) r_mem[priv_addr] <= priv_write_data;
    end
  end
endmodule

// File: tb/tb_priv_memory_responder.sv
// tb_priv_memory_responder: table vectors, random traffic vs. a rule-level model, and reset/scrub/saturation sequences
module tb_priv_memory_responder;
  logic clk = 0, reset = 1;
  logic [7:0] priv_addr = 0;
  logic [31:0] priv_write_data = 0;
  logic priv_write_enable = 0;
  logic [1:0] req_level = 0;
  logic [31:0] priv_read_data;
  logic ready, locked, viol_irq;
  logic [7:0] viol_addr, viol_count;
  int checks = 0, failures = 0;
  priv_memory_responder dut (
    .clk(clk), .reset(reset), .priv_addr(priv_addr), .priv_write_data(priv_write_data),
    .priv_write_enable(priv_write_enable), .req_level(req_level), .priv_read_data(priv_read_data),
    .ready(ready), .locked(locked), .viol_irq(viol_irq), .viol_addr(viol_addr), .viol_count(viol_count)
  );
  always #5 clk = ~clk;
  logic [31:0] m_mem [256];
  logic m_lock;
  logic [7:0] m_cnt, m_vaddr;
  logic [31:0] e_rd;
  logic e_irq;
  typedef struct {
    logic [7:0] a; logic [31:0] d; logic we; logic [1:0] lvl;
    logic [31:0] rd; logic irq; logic [7:0] cnt; logic lk;
  } vec_t;
  vec_t vt [11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
    m_lock = 0; m_cnt = 0; m_vaddr = 0;
  endtask
  function automatic logic may_write(input logic [7:0] a, input logic [1:0] l, input logic lk);
    case (a[7:6])
      2'd0: return 1;
      2'd1: return l >= 2 && !lk;
      default: return l == 3;
    endcase
  endfunction
  task automatic step(input logic [7:0] a, input logic [31:0] d, input logic we, input logic [1:0] l);
    logic ok, mask, viol;
    @(negedge clk);
    priv_addr = a; priv_write_data = d; priv_write_enable = we; req_level = l;
    ok = may_write(a, l, m_lock);
    mask = a[7:6] == 3 && l != 3;
    e_rd = mask ? 0 : m_mem[a];
    viol = we ? !ok : mask;
    e_irq = viol;
    if (viol) begin
      if (m_cnt == 0) m_vaddr = a;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 1;
    end
    if (we && ok) begin
      m_mem[a] = d;
      if (a == 8'h7F && d[0]) m_lock = 1;
    end
    @(posedge clk); #1;
    priv_write_enable = 0;
  endtask
  task automatic wait_ready(input int exp_cycles);
    int n = 0;
    while (!ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_latency", n, exp_cycles);
  endtask
  task automatic do_reset();
    @(negedge clk); reset = 1; priv_write_enable = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    @(negedge clk); reset = 0;
  endtask
  initial begin
    vt[0]  = '{8'h10, 32'hA5A5_0001, 1, 0, 32'h0, 0, 0, 0};
    vt[1]  = '{8'h10, 32'h0, 0, 0, 32'hA5A5_0001, 0, 0, 0};
    vt[2]  = '{8'h90, 32'hDEAD_BEEF, 1, 1, 32'h0, 1, 1, 0};
    vt[3]  = '{8'h90, 32'h0, 0, 0, 32'h0, 0, 1, 0};
    vt[4]  = '{8'h7F, 32'h1, 1, 2, 32'h0, 0, 1, 1};
    vt[5]  = '{8'h40, 32'h55, 1, 3, 32'h0, 1, 2, 1};
    vt[6]  = '{8'hC3, 32'hCAFE, 1, 3, 32'h0, 0, 2, 1};
    vt[7]  = '{8'hC3, 32'h0, 0, 3, 32'hCAFE, 0, 2, 1};
    vt[8]  = '{8'hC3, 32'h0, 0, 0, 32'h0, 1, 3, 1};
    vt[9]  = '{8'h40, 32'h0, 0, 3, 32'h0, 0, 3, 1};
    vt[10] = '{8'h7F, 32'h0, 0, 0, 32'h1, 0, 3, 1};
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", ready, 0);
    chk("rst_rdata", priv_read_data, 0);
    chk("rst_locked", locked, 0);
    chk("rst_irq", viol_irq, 0);
    chk("rst_count", viol_count, 0);
    chk("rst_vaddr", viol_addr, 0);
    @(negedge clk); reset = 0;
    wait_ready(256);
    step(8'h05, 0, 0, 0);
    chk("post_scrub_read", priv_read_data, 0);
    foreach (vt[i]) begin
      step(vt[i].a, vt[i].d, vt[i].we, vt[i].lvl);
      chk($sformatf("vec%0d_rdata", i), priv_read_data, vt[i].rd);
      chk($sformatf("vec%0d_irq", i), viol_irq, vt[i].irq);
      chk($sformatf("vec%0d_count", i), viol_count, vt[i].cnt);
      chk($sformatf("vec%0d_locked", i), locked, vt[i].lk);
    end
    chk("first_vaddr", viol_addr, 8'h90);
    step(8'h7F, 32'h0, 1, 3);
    chk("lock_sticky", locked, 1);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 7) == 0) ? 8'h7F : 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = {a[7:6], 6'h0A};
      step(a, $urandom, 1'($urandom), 2'($urandom));
      chk("rnd_rdata", priv_read_data, e_rd);
      chk("rnd_irq", viol_irq, e_irq);
      chk("rnd_count", viol_count, m_cnt);
      chk("rnd_vaddr", viol_addr, m_vaddr);
      chk("rnd_locked", locked, m_lock);
    end
    for (int i = 0; i < 300; i++) begin
      step(8'h80, 32'h1234, 1, 0);
      if (i < 2 || i > 297) chk("sat_irq", viol_irq, 1);
    end
    chk("sat_count", viol_count, 8'hFF);
    chk("sat_model", viol_count, m_cnt);
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    chk("midscrub_ready", ready, 0);
    chk("midscrub_locked", locked, 0);
    chk("midscrub_count", viol_count, 0);
    chk("midscrub_vaddr", viol_addr, 0);
    do_reset();
    wait_ready(256);
    step(8'h10, 0, 0, 0);
    chk("scrubbed_10", priv_read_data, 0);
    step(8'h7F, 0, 0, 0);
    chk("scrubbed_7F", priv_read_data, 0);
    step(8'h50, 32'h77, 1, 2);
    chk("unlocked_cfg_irq", viol_irq, 0);
    step(8'h50, 0, 0, 0);
    chk("unlocked_cfg_rd", priv_read_data, 32'h77);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
